// File: rtl/vga_text_writer.sv
// vga_text_writer
//   Character-cell writer for the VGA screen memory. Glyph requests are queued,
//   glyph words are fetched from an external font ROM and written to the
//   vga_ctrl write port one word per cycle. It also clears the whole screen and
//   can write inverted glyphs.
//
//   State | Meaning
//   IDLE  | waiting for a FIFO entry; pops and dispatches the head
//   FETCH | FontAddr = {code,0} presented to the ROM
//   WRITE | one glyph word written per cycle, next sub-word address issued
//   CLEAR | zero written to every screen word, one per cycle
//
// Ports
//   CLK_50, Reset_N            clock, async active-low reset
//   InValid/InReady            request handshake (InReady = FIFO not full)
//   InClear/InInvert/InCode/InCol/InRow  request fields
//   FontAddr/FontData          font ROM port ({code,k}; data one cycle later)
//   WrData/WrAddress/WrEn      screen-memory write port
//   Busy                       FSM active or FIFO non-empty
//   Err                        1-cycle pulse on a dropped out-of-range request
module vga_text_writer #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int CODE_W     = 7,
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int GLYPH_H    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                                           CLK_50,
  input  logic                                           Reset_N,
  input  logic                                           InValid,
  output logic                                           InReady,
  input  logic                                           InClear,
  input  logic                                           InInvert,
  input  logic [CODE_W-1:0]                              InCode,
  input  logic [6:0]                                     InCol,
  input  logic [5:0]                                     InRow,
  output logic [CODE_W+$clog2(GLYPH_H/(DATA_W/8))-1:0]   FontAddr,
  input  logic [DATA_W-1:0]                              FontData,
  output logic [DATA_W-1:0]                              WrData,
  output logic [ADDR_W-1:0]                              WrAddress,
  output logic                                           WrEn,
  output logic                                           Busy,
  output logic                                           Err
);

  localparam int WPG   = GLYPH_H / (DATA_W / 8);
  localparam int K_W   = $clog2(WPG);
  localparam int FA_W  = CODE_W + K_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 2 + CODE_W + 7 + 6;
  localparam int AW2   = ADDR_W + 2;
  localparam int TOTAL = COLS * ROWS * WPG;

  localparam logic [6:0]     COLS_L  = 7'(COLS);
  localparam logic [5:0]     ROWS_L  = 6'(ROWS);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  generate
    if (BASE_ADDR + TOTAL > 2**ADDR_W) begin : g_addr_chk
      $error("vga_text_writer: screen does not fit in ADDR_W address space");
    end
    if (GLYPH_H % (DATA_W / 8) != 0) begin : g_glyph_chk
      $error("vga_text_writer: GLYPH_H must be a multiple of DATA_W/8");
    end
  endgenerate

  // Request FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             full, empty, push, pop;
  logic             h_clr, h_inv;
  logic [CODE_W-1:0] h_code;
  logic [6:0]       h_col;
  logic [5:0]       h_row;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push  = InValid && !full;
  assign {h_clr, h_inv, h_code, h_col, h_row} = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge CLK_50) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {InClear, InInvert, InCode, InCol, InRow};
  end

  always_ff @(posedge CLK_50 or negedge Reset_N) begin
    if (!Reset_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // FSM and registered write port
  logic [1:0]        state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [6:0]        col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic              inv_q, inv_d;
  logic [FA_W-1:0]   fa_q, fa_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              err_q, err_d;
  logic [AW2-1:0]    glyph_addr, clr_addr;

  assign glyph_addr = AW2'(BASE_ADDR) + AW2'(row_q) * AW2'(COLS * WPG)
                    + AW2'(k_q) * AW2'(COLS) + AW2'(col_q);
  assign clr_addr   = AW2'(BASE_ADDR) + AW2'(cnt_q);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    col_d     = col_q;
    row_d     = row_q;
    inv_d     = inv_q;
    fa_d      = fa_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    err_d     = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (h_clr) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end else if (h_col >= COLS_L || h_row >= ROWS_L) begin
            err_d = 1'b1;
          end else begin
            state_d = S_FETCH;
            k_d     = '0;
            code_d  = h_code;
            col_d   = h_col;
            row_d   = h_row;
            inv_d   = h_inv;
            fa_d    = {h_code, K_W'(0)};
          end
        end
      end
      S_FETCH: begin
        // ROM answers sub-word 0 during the first WRITE cycle; queue sub-word 1 now.
        state_d = S_WRITE;
        fa_d    = {code_q, K_W'(1)};
      end
      S_WRITE: begin
        wr_en_d   = 1'b1;
        wr_data_d = FontData ^ {DATA_W{inv_q}};
        wr_addr_d = ADDR_W'(glyph_addr);
        if (k_q == K_W'(WPG - 1)) begin
          state_d = S_IDLE;
        end else begin
          k_d = k_q + K_W'(1);
          if (int'(k_q) + 2 < WPG) fa_d = {code_q, K_W'(int'(k_q) + 2)};
        end
      end
      default: begin
        wr_en_d   = 1'b1;
        wr_data_d = '0;
        wr_addr_d = ADDR_W'(clr_addr);
        if (cnt_q == ADDR_W'(TOTAL - 1)) state_d = S_IDLE;
        else cnt_d = cnt_q + ADDR_W'(1);
      end
    endcase
  end

  always_ff @(posedge CLK_50 or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      code_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      inv_q     <= 1'b0;
      fa_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      col_q     <= col_d;
      row_q     <= row_d;
      inv_q     <= inv_d;
      fa_q      <= fa_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
    end
  end

  assign InReady   = !full;
  assign FontAddr  = fa_q;
  assign WrEn      = wr_en_q;
  assign WrData    = wr_data_q;
  assign WrAddress = wr_addr_q;
  assign Err       = err_q;
  assign Busy      = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_vga_text_writer.sv
module tb_vga_text_writer;

  logic        CLK_50 = 1'b0;
  logic        Reset_N;
  logic        InValid, InReady, InClear, InInvert;
  logic [6:0]  InCode;
  logic [6:0]  InCol;
  logic [5:0]  InRow;
  logic [7:0]  FontAddr;
  logic [31:0] FontData;
  logic [31:0] WrData;
  logic [12:0] WrAddress;
  logic        WrEn, Busy, Err;

  vga_text_writer dut (
    .CLK_50(CLK_50), .Reset_N(Reset_N), .InValid(InValid), .InReady(InReady),
    .InClear(InClear), .InInvert(InInvert), .InCode(InCode), .InCol(InCol),
    .InRow(InRow), .FontAddr(FontAddr), .FontData(FontData), .WrData(WrData),
    .WrAddress(WrAddress), .WrEn(WrEn), .Busy(Busy), .Err(Err)
  );

  always #5 CLK_50 = ~CLK_50;

  // Font ROM: one-cycle read latency.
  logic [31:0] font_mem [256];
  always @(posedge CLK_50) FontData <= font_mem[FontAddr];

  typedef struct { logic [12:0] a; logic [31:0] d; } wr_t;
  wr_t expq[$];
  int  log_a[$];
  logic [31:0] log_d[$];
  int  log_c[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int err_seen = 0, err_exp = 0;
  int acc_cyc, last_wait;
  logic [12:0] last_a = '0;
  logic [31:0] last_d = '0;

  always @(posedge CLK_50) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: every accepted request expands into its list of writes.
  task automatic model_push(input bit clr, input bit inv, input int code, input int col, input int row);
    wr_t w;
    if (clr) begin
      for (int i = 0; i < 4800; i++) begin
        w.a = 13'(i); w.d = '0; expq.push_back(w);
      end
    end else if (col >= 80 || row >= 30) begin
      err_exp++;
    end else begin
      for (int k = 0; k < 2; k++) begin
        w.a = 13'(row * 160 + k * 80 + col);
        w.d = font_mem[code * 2 + k] ^ {32{inv}};
        expq.push_back(w);
      end
    end
  endtask

  // Compare process
  always @(negedge CLK_50) begin
    if (Reset_N) begin
      if (WrEn) begin
        if (expq.size() == 0) begin
          chk("unexpected_write", 32'(WrAddress), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = expq.pop_front();
          chk("wr_addr", 32'(WrAddress), 32'(e.a));
          chk("wr_data", WrData, e.d);
        end
        log_a.push_back(int'(WrAddress));
        log_d.push_back(WrData);
        log_c.push_back(cyc);
      end else begin
        chk("hold_addr", 32'(WrAddress), 32'(last_a));
        chk("hold_data", WrData, last_d);
      end
      last_a = WrAddress;
      last_d = WrData;
      if (Err) err_seen++;
    end
  end

  task automatic send(input bit clr, input bit inv, input int code, input int col, input int row);
    int t = 0;
    @(negedge CLK_50);
    InClear = clr; InInvert = inv; InCode = 7'(code); InCol = 7'(col); InRow = 6'(row);
    InValid = 1'b1;
    while (!InReady && t < 6000) begin
      @(negedge CLK_50);
      t++;
    end
    last_wait = t;
    if (!InReady) begin
      chk("send_timeout", 32'(InReady), 32'd1);
    end else begin
      model_push(clr, inv, code, col, row);
      acc_cyc = cyc;
    end
    @(posedge CLK_50);
    #1 InValid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((Busy || expq.size() != 0) && t < 20000) begin
      @(negedge CLK_50);
      t++;
    end
    if (t >= 20000) chk("idle_timeout", 32'(Busy), 32'd0);
    repeat (2) @(negedge CLK_50);
  endtask

  initial begin
    int n0, e0, t;
    for (int i = 0; i < 256; i++) font_mem[i] = $urandom;
    font_mem[8'hA0] = 32'h3F33333F;
    font_mem[8'hA1] = 32'h0F0F1234;

    Reset_N = 1'b0; InValid = 0; InClear = 0; InInvert = 0; InCode = 0; InCol = 0; InRow = 0;
    #7;
    chk("rst_wren", 32'(WrEn), 0);
    chk("rst_wrdata", WrData, 0);
    chk("rst_wraddr", 32'(WrAddress), 0);
    chk("rst_fontaddr", 32'(FontAddr), 0);
    chk("rst_err", 32'(Err), 0);
    chk("rst_busy", 32'(Busy), 0);
    repeat (2) @(negedge CLK_50);
    Reset_N = 1'b1;
    #1 chk("rst_inready", 32'(InReady), 1);

    // 1: plain glyph, latency and back-to-back words
    n0 = log_a.size();
    send(0, 0, 8'h50, 1, 0);
    wait_idle();
    chk("t1_count", 32'(log_a.size() - n0), 2);
    if (log_a.size() - n0 == 2) begin
      chk("t1_addr0", 32'(log_a[n0]), 32'h01);
      chk("t1_addr1", 32'(log_a[n0+1]), 32'h51);
      chk("t1_data0", log_d[n0], 32'h3F33333F);
      chk("t1_data1", log_d[n0+1], 32'h0F0F1234);
      chk("t1_latency", 32'(log_c[n0] - acc_cyc), 4);
      chk("t1_b2b", 32'(log_c[n0+1] - log_c[n0]), 1);
    end

    // 2: invert
    n0 = log_a.size();
    send(0, 1, 8'h50, 1, 0);
    wait_idle();
    chk("t2_count", 32'(log_a.size() - n0), 2);
    if (log_a.size() - n0 == 2) chk("t2_data0", log_d[n0], 32'hC0CCCCC0);

    // 3: corner cell, then out-of-range column
    n0 = log_a.size();
    send(0, 0, 3, 79, 29);
    wait_idle();
    chk("t3_count", 32'(log_a.size() - n0), 2);
    if (log_a.size() - n0 == 2) begin
      chk("t3_addr0", 32'(log_a[n0]), 4719);
      chk("t3_addr1", 32'(log_a[n0+1]), 4799);
    end
    n0 = log_a.size(); e0 = err_seen;
    send(0, 0, 3, 80, 0);
    wait_idle();
    chk("t3_nowrite", 32'(log_a.size() - n0), 0);
    chk("t3_err", 32'(err_seen - e0), 1);
    chk("t3_busy", 32'(Busy), 0);

    // 4+5: clear, then 5 glyphs queued behind it; the fifth must stall
    n0 = log_a.size();
    send(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      send(0, i[0], 10 + i, i, i + 1);
      if (i < 4) chk("t4_nostall", 32'(last_wait), 0);
      else chk("t4_stall", 32'(last_wait > 0), 1);
    end
    wait_idle();
    chk("t5_count", 32'(log_a.size() - n0), 4810);
    if (log_a.size() - n0 == 4810) begin
      chk("t5_last_clr_addr", 32'(log_a[n0+4799]), 4799);
      chk("t5_last_clr_data", log_d[n0+4799], 0);
      chk("t5_clr_span", 32'(log_c[n0+4799] - log_c[n0]), 4799);
      chk("t4_first_glyph", 32'(log_a[n0+4800]), 160);
    end

    // Random requests
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK_50);
      send(0, 1'($urandom_range(0, 1)), $urandom_range(0, 127),
           $urandom_range(0, 84), $urandom_range(0, 32));
    end
    wait_idle();
    chk("rand_err", 32'(err_seen), 32'(err_exp));

    // 6: reset in the middle of a glyph
    send(0, 0, 7, 5, 2);
    t = 0;
    @(negedge CLK_50);
    while (!WrEn && t < 20) begin
      @(negedge CLK_50);
      t++;
    end
    chk("t6_reached_write", 32'(WrEn), 1);
    #2 Reset_N = 1'b0;
    #1;
    chk("t6_wren", 32'(WrEn), 0);
    chk("t6_busy", 32'(Busy), 0);
    expq.delete();
    last_a = '0; last_d = '0;
    repeat (2) @(negedge CLK_50);
    Reset_N = 1'b1;
    #1;
    chk("t6_inready", 32'(InReady), 1);
    chk("t6_busy_after", 32'(Busy), 0);
    n0 = log_a.size();
    send(0, 1, 9, 6, 3);
    wait_idle();
    chk("t6_recover", 32'(log_a.size() - n0), 2);

    chk("final_queue", 32'(expq.size()), 0);
    chk("final_err", 32'(err_seen), 32'(err_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
